eprisc_bus_target: RTL and testbench
====================================

Name: eprisc_bus_target

Overview:
I/O-controller-side front end of the epRISC peripheral bus, directly downstream of the machine's bus master.
- Oversamples the master's bus clock, select, and 8-bit MOSI in the iBoardClock domain.
- Decodes command/address/data transactions and presents single-cycle register read/write strobes to the I/O register file.
- Drives MISO read data and the registered bus interrupt back to the machine.

Parameters:
DEVICE_SELECT, 2'd1, iBusSelect value addressing this target; 2'd0 = bus idle.
READ_WAIT, 4, max iBoardClock cycles from oRegRead to iRegReady before the read is declared late.

Ports:
iBoardClock  in  1  system clock, all state on rising edge
iBoardReset  in  1  asynchronous, active-low reset
iBusClock  in  1  bus clock from master; async to iBoardClock
iBusSelect  in  [0:1]  target select from master
iBusMOSI  in  [0:7]  master-to-target byte; bit 0 = MSB
oBusMISO  out  [0:7]  target-to-master byte
oBusInterrupt  out  1  registered OR of iIrqPending
oBusError  out  1  sticky late-read flag; cleared by reset or by a write to address 7'h7F
oRegAddr  out  [0:6]  register address
oRegWriteData  out  [0:31]  write data
oRegWrite  out  1  one-cycle write strobe
oRegRead  out  1  one-cycle read strobe
iRegReadData  in  [0:31]  read data, valid while iRegReady=1
iRegReady  in  1  read data valid
iIrqPending  in  [0:7]  peripheral interrupt requests

Behaviour:
- Reset values: all outputs 0; oBusMISO = 8'h00; state = IDLE; synchronizers cleared.
- Input synchronization:
  - iBusClock and iBusSelect pass through 2-flop synchronizers.
  - A rising edge is detected on the synchronized clock; iBusMOSI is captured on the cycle the edge is detected.
  - Master guarantees MOSI stable ≥1 cycle before the raw edge, and each bus clock phase ≥4 iBoardClock cycles.
- Selected: synchronized select == DEVICE_SELECT. Any non-matching select value in any state returns to IDLE. An aborted transaction issues no further strobes; oBusMISO returns to 8'h00.
- Byte 0 = {rw, addr[6:0]}; rw=1 write, rw=0 read. oRegAddr is latched from byte 0.
- States:
  - IDLE: on select go to CMD; byte counter = 0.
  - CMD: on a rising edge, latch byte 0; go to WDATA if rw=1, else RTURN.
  - WDATA: shift 4 bytes MSB-first into oRegWriteData. oRegWrite pulses 1 cycle, the cycle after the 4th byte is captured; then go to DONE.
  - RTURN:
    - On entry, pulse oRegRead for 1 cycle and wait for iRegReady.
    - If iRegReady arrives within READ_WAIT cycles, latch iRegReadData.
    - Otherwise latch 32'hFFFF_FFFF and set oBusError.
    - The master's byte 1 is a dummy; on its rising edge go to RDATA.
  - RDATA: oBusMISO updates on each detected falling edge, driving latched bytes [0:7], [8:15], [16:23], [24:31] for master bytes 2–5. After the 4th byte's rising edge, go to DONE.
  - DONE: oBusMISO = 8'h00; ignore further edges until deselect, then go to IDLE.
- oBusInterrupt = registered |iIrqPending (1-cycle latency), independent of state.
- Write to 7'h7F: clears oBusError in the strobe cycle; oRegWrite still pulses.
- Simultaneous iRegReady and timeout expiry: the data wins.
- Reset mid-transaction: immediate return to reset values; the next transaction requires a fresh select.

Optional Feature:
EPRISC_BUS_ECHO_EN
- Defined: in CMD and WDATA, oBusMISO echoes the most recently captured MOSI byte, updated on the falling edge after capture, for master-side link checking.
- Undefined: oBusMISO = 8'h00 outside RDATA.

Test Plan:
- Write: select=1, bytes 8'h85, DE, AD, BE, EF → one oRegWrite pulse with oRegAddr=7'h05, oRegWriteData=32'hDEADBEEF; no oRegRead.
- Read: bytes 8'h12 + 5 dummies, iRegReady 2 cycles after oRegRead with 32'h01234567 → MISO bytes 2–5 = 01, 23, 45, 67; oBusError=0.
- Late read: iRegReady never asserted → MISO FF, FF, FF, FF; oBusError=1. Then write byte 8'hFF + 4 data bytes → oBusError=0.
- Abort: deselect after 2 write data bytes → no oRegWrite, state IDLE. Next full write completes correctly.
- Interrupt/select: iIrqPending=8'h20 → oBusInterrupt=1 one cycle later. Select=2 transaction → no strobes, MISO=8'h00.
- Reset mid-read (iBoardReset=0 during RDATA) → all outputs 0 immediately. With EPRISC_BUS_ECHO_EN, write 8'h85 → MISO shows 8'h85 after the next falling edge.

Source files
------------

// File: rtl/eprisc_bus_target.sv
// epRISC peripheral bus target: oversamples the master's bus and turns transactions into register strobes.
// Optional EPRISC_BUS_ECHO_EN: echo the last captured MOSI byte on MISO during CMD/WDATA.
module eprisc_bus_target #(
   parameter logic [1:0] DEVICE_SELECT = 2'd1,
   parameter int         READ_WAIT     = 4
) (
   input  logic        iBoardClock,
   input  logic        iBoardReset,
   input  logic        iBusClock,
   input  logic [0:1]  iBusSelect,
   input  logic [0:7]  iBusMOSI,
   output logic [0:7]  oBusMISO,
   output logic        oBusInterrupt,
   output logic        oBusError,
   output logic [0:6]  oRegAddr,
   output logic [0:31] oRegWriteData,
   output logic        oRegWrite,
   output logic        oRegRead,
   input  logic [0:31] iRegReadData,
   input  logic        iRegReady,
   input  logic [0:7]  iIrqPending
);
   typedef enum logic [2:0] {IDLE, CMD, WDATA, RTURN, RDATA, DONE} busState;

   busState     state, stateNext;
   logic        busClkMeta, busClkSync, busClkPrev;
   logic [0:1]  selMeta, selSync;
   logic        busRise, busFall, selected;
   logic [1:0]  byteCnt;
   logic [7:0]  waitCnt;
   logic        readDone, readPending, dataTake, lateRead;
   logic [0:31] readLatch;
   logic [0:7]  readByte;
   logic        wrPulse, rdPulse;
`ifdef EPRISC_BUS_ECHO_EN
   logic [0:7]  lastMosi;
`endif

   assign busRise  = busClkSync & ~busClkPrev;
   assign busFall  = ~busClkSync & busClkPrev;
   assign selected = (selSync == DEVICE_SELECT);

   // The dummy byte's rising edge forces a late verdict if the register file is still silent.
   assign readPending = selected && (state == RTURN) && !readDone;
   assign dataTake    = readPending && iRegReady;
   assign lateRead    = readPending && !iRegReady && ((waitCnt == 8'(READ_WAIT)) || busRise);

   always_comb begin
      case (byteCnt)
         2'd0:    readByte = readLatch[0:7];
         2'd1:    readByte = readLatch[8:15];
         2'd2:    readByte = readLatch[16:23];
         default: readByte = readLatch[24:31];
      endcase
   end

   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) state <= IDLE;
      else              state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      wrPulse   = 1'b0;
      rdPulse   = 1'b0;
      if (!selected) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE:  stateNext = CMD;
            CMD: begin
               if (busRise) begin
                  if (iBusMOSI[0]) begin
                     stateNext = WDATA;
                  end else begin
                     stateNext = RTURN;
                     rdPulse   = 1'b1;
                  end
               end
            end
            WDATA: begin
               if (busRise && byteCnt == 2'd3) begin
                  stateNext = DONE;
                  wrPulse   = 1'b1;
               end
            end
            RTURN: if (busRise) stateNext = RDATA;
            RDATA: if (busRise && byteCnt == 2'd3) stateNext = DONE;
            default: stateNext = state;
         endcase
      end
   end

   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         busClkMeta    <= 1'b0;
         busClkSync    <= 1'b0;
         busClkPrev    <= 1'b0;
         selMeta       <= '0;
         selSync       <= '0;
         oBusInterrupt <= 1'b0;
         oBusError     <= 1'b0;
         oBusMISO      <= '0;
         oRegAddr      <= '0;
         oRegWriteData <= '0;
         oRegWrite     <= 1'b0;
         oRegRead      <= 1'b0;
         byteCnt       <= '0;
         waitCnt       <= '0;
         readDone      <= 1'b0;
`ifdef EPRISC_BUS_ECHO_EN
         lastMosi      <= '0;
`endif
      end else begin
         busClkMeta    <= iBusClock;
         busClkSync    <= busClkMeta;
         busClkPrev    <= busClkSync;
         selMeta       <= iBusSelect;
         selSync       <= selMeta;
         oBusInterrupt <= |iIrqPending;
         oRegWrite     <= wrPulse;
         oRegRead      <= rdPulse;

         if (stateNext != state) byteCnt <= '0;
         else if (busRise)       byteCnt <= byteCnt + 2'd1;

         if (state == CMD && busRise) oRegAddr <= iBusMOSI[1:7];
         if (state == WDATA && busRise) oRegWriteData <= {oRegWriteData[8:31], iBusMOSI};
`ifdef EPRISC_BUS_ECHO_EN
         if ((state == CMD || state == WDATA) && busRise) lastMosi <= iBusMOSI;
`endif

         if (rdPulse) begin
            waitCnt  <= '0;
            readDone <= 1'b0;
         end else if (dataTake || lateRead) begin
            readDone <= 1'b1;
         end else if (readPending) begin
            waitCnt  <= waitCnt + 8'd1;
         end

         // Address 7F is the error-clear register; the write strobe itself still goes out.
         if (wrPulse && oRegAddr == 7'h7F) oBusError <= 1'b0;
         else if (lateRead)                 oBusError <= 1'b1;

         if (stateNext == IDLE || stateNext == DONE || stateNext == RTURN) oBusMISO <= '0;
         else if (state == RDATA && busFall) oBusMISO <= readByte;
`ifdef EPRISC_BUS_ECHO_EN
         else if ((state == CMD || state == WDATA) && busFall) oBusMISO <= lastMosi;
`endif
      end
   end

   always_ff @(posedge iBoardClock) begin
      if (dataTake)      readLatch <= iRegReadData;
      else if (lateRead) readLatch <= '1;
   end
endmodule

// File: tb/tb_eprisc_bus_target.sv
// Scoreboard bench for eprisc_bus_target: a bus-master driver pushes expectations, monitors pop them.
module tb_eprisc_bus_target;
   localparam logic [1:0] DEV  = 2'd1;
   localparam int         RW   = 4;
   localparam int         HALF = 6;
`ifdef EPRISC_BUS_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        iBoardReset = 1'b0;
   logic        iBusClock = 1'b0;
   logic [0:1]  iBusSelect = '0;
   logic [0:7]  iBusMOSI = '0;
   logic [0:7]  oBusMISO;
   logic        oBusInterrupt, oBusError, oRegWrite, oRegRead;
   logic [0:6]  oRegAddr;
   logic [0:31] oRegWriteData;
   logic [0:31] iRegReadData = '0;
   logic        iRegReady = 1'b0;
   logic [0:7]  iIrqPending = '0;

   typedef struct {logic [6:0] a; logic [31:0] d;} wrExp;
   wrExp       wrQ[$];
   logic [6:0] rdQ[$];
   logic [7:0] misoQ[$];
   int         checks = 0;
   int         errors = 0;
   logic       modelErr = 1'b0;
   int         rdDelay = -1;
   logic [31:0] rdData = '0;

   eprisc_bus_target #(.DEVICE_SELECT(DEV), .READ_WAIT(RW)) dut (
      .iBoardClock(clk), .iBoardReset(iBoardReset), .iBusClock(iBusClock),
      .iBusSelect(iBusSelect), .iBusMOSI(iBusMOSI), .oBusMISO(oBusMISO),
      .oBusInterrupt(oBusInterrupt), .oBusError(oBusError), .oRegAddr(oRegAddr),
      .oRegWriteData(oRegWriteData), .oRegWrite(oRegWrite), .oRegRead(oRegRead),
      .iRegReadData(iRegReadData), .iRegReady(iRegReady), .iIrqPending(iIrqPending));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chkAllZero(input string nm);
      chk({nm, ".miso"}, 32'(oBusMISO), 0);
      chk({nm, ".irq"}, 32'(oBusInterrupt), 0);
      chk({nm, ".err"}, 32'(oBusError), 0);
      chk({nm, ".addr"}, 32'(oRegAddr), 0);
      chk({nm, ".wdata"}, oRegWriteData, 0);
      chk({nm, ".strobes"}, {30'd0, oRegWrite, oRegRead}, 0);
   endtask

   // Register-file responder: answers each read strobe after rdDelay cycles (negative = never).
   initial begin
      forever begin
         @(negedge clk);
         if (iBoardReset && oRegRead && rdDelay >= 0) begin
            repeat (rdDelay) @(negedge clk);
            iRegReadData = rdData;
            iRegReady = 1'b1;
            @(negedge clk);
            iRegReady = 1'b0;
            iRegReadData = '0;
         end
      end
   end

   // Strobe monitor.
   always @(negedge clk) begin
      if (iBoardReset) begin
         if (oRegWrite) begin
            if (wrQ.size() == 0) chk("unexpectedWrite", 1, 0);
            else begin
               wrExp e;
               e = wrQ.pop_front();
               chk("wrAddr", 32'(oRegAddr), 32'(e.a));
               chk("wrData", oRegWriteData, e.d);
               if (e.a == 7'h7F) chk("errClearInStrobe", 32'(oBusError), 0);
            end
         end
         if (oRegRead) begin
            if (rdQ.size() == 0) chk("unexpectedRead", 1, 0);
            else chk("rdAddr", 32'(oRegAddr), 32'(rdQ.pop_front()));
         end
      end
   end

   // MISO monitor: the master samples on each bus-clock rising edge.
   always @(posedge iBusClock) begin
      if (misoQ.size() == 0) chk("unexpectedMisoSample", 1, 0);
      else chk("miso", 32'(oBusMISO), 32'(misoQ.pop_front()));
   end

   task automatic xfer(input logic [1:0] sel, input logic rw, input logic [6:0] addr,
                       input logic [31:0] data, input int nData, input int dly, input int rstAt);
      logic [7:0]  b [0:5];
      logic [31:0] resp;
      logic [7:0]  prev;
      bit          hit, late;
      int          nb;
      hit  = (sel == DEV);
      nb   = rw ? 1 + nData : 6;
      late = (dly < 0) || (dly > RW);
      resp = late ? 32'hFFFF_FFFF : data;
      b[0] = {rw, addr};
      for (int i = 1; i < 6; i++)
         b[i] = (rw && i <= 4) ? 8'(data >> (8 * (4 - i))) : 8'($urandom);
      rdDelay = dly;
      rdData  = data;
      for (int i = 0; i < nb; i++) begin
         if (rstAt >= 0 && i > rstAt) break;
         prev = (i > 0) ? b[i-1] : 8'h00;
         if (!hit)    misoQ.push_back(8'h00);
         else if (rw) misoQ.push_back(ECHO ? prev : 8'h00);
         else         misoQ.push_back(i >= 2 ? 8'(resp >> (8 * (5 - i))) : 8'h00);
      end
      if (hit && rw && nData == 4) begin
         wrQ.push_back('{addr, data});
         if (addr == 7'h7F) modelErr = 1'b0;
      end
      if (hit && !rw) begin
         rdQ.push_back(addr);
         if (late) modelErr = 1'b1;
      end

      iBusSelect = sel;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         iBusMOSI = b[i];
         repeat (HALF) @(negedge clk);
         iBusClock = 1'b1;
         if (i == rstAt) begin
            repeat (2) @(negedge clk);
            iBoardReset = 1'b0;
            #1;
            chkAllZero("midReset");
            modelErr = 1'b0;
            iBusSelect = '0;
            iBusClock = 1'b0;
            repeat (2) @(negedge clk);
            iBoardReset = 1'b1;
            break;
         end
         repeat (HALF) @(negedge clk);
         iBusClock = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      iBusSelect = '0;
      iBusClock  = 1'b0;
      iBusMOSI   = '0;
      repeat (6) @(negedge clk);
      chk("busError", 32'(oBusError), 32'(modelErr));
      chk("misoIdle", 32'(oBusMISO), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] irq;
      logic       irqPrev;
      repeat (3) @(negedge clk);
      #1;
      chkAllZero("inReset");
      iBoardReset = 1'b1;
      repeat (3) @(negedge clk);
      chkAllZero("afterReset");

      xfer(2'd1, 1'b1, 7'h05, 32'hDEAD_BEEF, 4, 0, -1);
      xfer(2'd1, 1'b0, 7'h12, 32'h0123_4567, 0, 2, -1);
      xfer(2'd1, 1'b0, 7'h12, 32'h0123_4567, 0, -1, -1);
      chk("lateErrSet", 32'(oBusError), 1);
      xfer(2'd1, 1'b1, 7'h7F, 32'h1122_3344, 4, 0, -1);
      chk("errCleared", 32'(oBusError), 0);
      xfer(2'd1, 1'b1, 7'h05, 32'hDEAD_BEEF, 2, 0, -1);
      xfer(2'd1, 1'b1, 7'h05, 32'hCAFE_F00D, 4, 0, -1);
      xfer(2'd1, 1'b0, 7'h33, 32'hA5A5_5A5A, 0, RW, -1);
      xfer(2'd1, 1'b0, 7'h34, 32'h5A5A_A5A5, 0, RW + 1, -1);
      xfer(2'd2, 1'b0, 7'h12, 32'h0123_4567, 0, 0, -1);
      xfer(2'd2, 1'b1, 7'h05, 32'h0BAD_F00D, 4, 0, -1);
      xfer(2'd1, 1'b0, 7'h21, 32'h89AB_CDEF, 0, 1, 3);

      iIrqPending = 8'h20;
      #1;
      chk("irqLatency", 32'(oBusInterrupt), 0);
      @(negedge clk);
      chk("irqSet", 32'(oBusInterrupt), 1);
      irqPrev = 1'b1;
      for (int k = 0; k < 6; k++) begin
         irq = (k % 2 == 0) ? 8'h00 : 8'($urandom | 1);
         iIrqPending = irq;
         #1;
         chk("irqHold", 32'(oBusInterrupt), 32'(irqPrev));
         @(negedge clk);
         chk("irqRand", 32'(oBusInterrupt), 32'(irq != 0));
         irqPrev = (irq != 0);
      end
      iIrqPending = '0;
      @(negedge clk);

      for (int t = 0; t < 24; t++) begin
         logic [1:0] sel;
         logic       rw;
         logic [6:0] addr;
         int         nData, dly, pick;
         pick  = $urandom_range(0, 7);
         sel   = (pick < 5) ? 2'd1 : 2'(pick - 3);
         rw    = 1'($urandom);
         addr  = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom);
         nData = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 4;
         dly   = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, RW + 2);
         xfer(sel, rw, addr, 32'($urandom), nData, dly, -1);
      end

      chk("wrQEmpty", 32'(wrQ.size()), 0);
      chk("rdQEmpty", 32'(rdQ.size()), 0);
      chk("misoQEmpty", 32'(misoQ.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
